// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that fills the instruction memory from a byte
// stream (16-bit big-endian word count, then N big-endian 32-bit words) and
// holds the pipeline in reset until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte (CHK state + 8-bit accumulator); a mismatch ends in ERROR.
module imem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned CNT_W = 17;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_FLUSH,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_cnt_hi;
  logic [IDX_W-1:0]  r_last_idx;
  logic [IDX_W-1:0]  r_idx;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_asm;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_xor;
`endif

  logic              r_rx_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_cpu_reset;
  logic              r_done;
  logic              r_error;

  logic              w_accept;
  logic [15:0]       w_count;
  logic              w_word_end;
  logic              w_last_word;
  logic              w_rdy_next;

  assign w_accept    = rx_valid & r_rx_ready;
  assign w_count     = {r_cnt_hi, rx_byte};
  assign w_word_end  = w_accept && (r_state == S_DATA) && (r_bcnt == 2'd3);
  assign w_last_word = (r_idx == r_last_idx);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_CNT_HI;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and the ready level the next state will present
  always_comb begin
    w_next     = r_state;
    w_rdy_next = 1'b0;
    case (r_state)
      S_CNT_HI: begin
        if (w_accept) w_next = S_CNT_LO;
      end
      S_CNT_LO: begin
        if (w_accept) begin
          if ((w_count == 16'd0) || ({1'b0, w_count} > MAX_WORDS)) begin
            w_next = S_ERROR;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_word_end && w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_FLUSH;
`endif
        end
      end
      S_FLUSH: begin
        w_next = S_DONE;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) begin
          w_next = ((r_xor ^ rx_byte) == 8'h00) ? S_DONE : S_ERROR;
        end
      end
`endif
      S_DONE:  w_next = S_DONE;
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_ERROR;
    endcase
    case (w_next)
      S_CNT_HI, S_CNT_LO, S_DATA: w_rdy_next = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:                      w_rdy_next = 1'b1;
`endif
      default:                    w_rdy_next = 1'b0;
    endcase
  end

  // Count capture, word assembly and word index
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt_hi   <= 8'h00;
      r_last_idx <= '0;
      r_idx      <= '0;
      r_bcnt     <= 2'd0;
      r_asm      <= 24'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor      <= 8'h00;
`endif
    end else if (w_accept) begin
      case (r_state)
        S_CNT_HI: r_cnt_hi <= rx_byte;
        S_CNT_LO: begin
          r_last_idx <= IDX_W'(w_count - 16'd1);
          r_idx      <= '0;
          r_bcnt     <= 2'd0;
        end
        S_DATA: begin
          r_asm  <= {r_asm[15:0], rx_byte};
          r_bcnt <= r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor <= r_xor ^ rx_byte;
`endif
    end
  end

  // Registered outputs, all derived from the state being entered
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= 32'h0;
      r_cpu_reset  <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_rx_ready  <= w_rdy_next;
      r_imem_we   <= w_word_end;
      if (w_word_end) begin
        r_imem_addr  <= r_idx[ADDR_W-1:0];
        r_imem_wdata <= {r_asm, rx_byte};
      end
      r_done      <= (w_next == S_DONE);
      r_error     <= (w_next == S_ERROR);
      r_cpu_reset <= (w_next != S_DONE);
    end
  end

  assign rx_ready   = r_rx_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus for imem_loader with a stream-level model
// (expected write list and final status derived from the byte stream).
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  int n_tests = 0;
  int n_fail  = 0;
  logic check_en = 1'b0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [7:0]         stream_q[$];
  logic [31:0]        words[$];
  logic               m_done;
  logic               m_error;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the expected write list and status rules
  always @(negedge clk) begin : cmp
    logic [ADDR_W+31:0] e;
    if (check_en) begin
      check("cpu_reset_until_done", cpu_reset, !done);
      if (done || error) check("rx_ready_when_idle", rx_ready, 1'b0);
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", imem_we, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", imem_addr, e[ADDR_W+31:32]);
          check("wr_data", imem_wdata, e[31:0]);
        end
      end
    end
  end

  // Model: byte stream plus the writes and end status it must produce
  task automatic build(input int unsigned count, input logic [7:0] chk_flip);
    logic [7:0] x;
    logic       valid;
    stream_q.delete();
    stream_q.push_back(8'(count >> 8));
    stream_q.push_back(8'(count));
    foreach (words[i])
      for (int s = 3; s >= 0; s--) stream_q.push_back(8'(words[i] >> (8 * s)));
    valid = (count >= 1) && (count <= (2 ** ADDR_W));
    if (valid)
      for (int i = 0; i < int'(count); i++) exp_q.push_back({ADDR_W'(i), words[i]});
    m_done  = valid;
    m_error = !valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (valid) begin
      x = 8'h00;
      foreach (stream_q[i]) x ^= stream_q[i];
      stream_q.push_back(x ^ chk_flip);
      m_done  = (chk_flip == 8'h00);
      m_error = (chk_flip != 8'h00);
    end
`else
    x = chk_flip;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_byte  = b;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        rx_valid = 1'b0;
        return;
      end
    end
    check("ready_timeout", rx_ready, 1'b1);
    rx_valid = 1'b0;
  endtask

  task automatic send_all(input int gapmax);
    foreach (stream_q[i]) send_byte(stream_q[i], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
  endtask

  task automatic finish_check(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_done"}, done, m_done);
    check({tag, "_error"}, error, m_error);
    check({tag, "_cpu_reset"}, cpu_reset, !m_done);
    check({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_imem_we", imem_we, 1'b0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 32'h0);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_rise", rx_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    check_en = 1'b1;

    // Basic load, back to back, with literal pins on the two writes
    words.delete();
    words.push_back(32'h20010005);
    words.push_back(32'h00221820);
    build(2, 8'h00);
    foreach (stream_q[i]) begin
      send_byte(stream_q[i], 0);
      if (i == 5) begin
        check("basic_w0_we", imem_we, 1'b1);
        check("basic_w0_addr", imem_addr, 0);
        check("basic_w0_data", imem_wdata, 32'h20010005);
      end
      if (i == 9) begin
        check("basic_w1_we", imem_we, 1'b1);
        check("basic_w1_addr", imem_addr, 1);
        check("basic_w1_data", imem_wdata, 32'h00221820);
        check("basic_not_done_yet", done, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("basic_flush_ready", rx_ready, 1'b0);
        @(posedge clk); #1;
        check("basic_done_edge", done, 1'b1);
        check("basic_cpu_reset_edge", cpu_reset, 1'b0);
`endif
      end
    end
    finish_check("basic");

    // Bytes offered after completion are never taken
    rx_valid = 1'b1;
    rx_byte  = 8'hFF;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    check("post_done_sticky", done, m_done);

    // Same stream with random valid gaps
    apply_reset();
    build(2, 8'h00);
    send_all(5);
    finish_check("gaps");

    // Count zero
    apply_reset();
    words.delete();
    build(0, 8'h00);
    send_all(0);
    check("cnt0_error", error, 1'b1);
    check("cnt0_ready", rx_ready, 1'b0);
    check("cnt0_cpu_reset", cpu_reset, 1'b1);
    repeat (5) @(negedge clk);
    finish_check("cnt0");

    // Count 1025 is too large
    apply_reset();
    build(1025, 8'h00);
    send_all(0);
    check("cnt1025_error", error, 1'b1);
    finish_check("cnt1025");

    // Full memory: 1024 words
    apply_reset();
    words.delete();
    for (int i = 0; i < 1024; i++) words.push_back((32'(i) * 32'h9E3779B1) ^ 32'hA5A50000);
    build(1024, 8'h00);
    send_all(0);
    check("full_last_addr", imem_addr, 32'd1023);
    finish_check("full");

    // Reset mid word 0, then a fresh load
    apply_reset();
    words.delete();
    words.push_back(32'h20010005);
    words.push_back(32'h00221820);
    build(2, 8'h00);
    for (int i = 0; i < 4; i++) send_byte(stream_q[i], 0);
    apply_reset();
    build(2, 8'h00);
    send_all(1);
    finish_check("reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good and bad
    apply_reset();
    words.delete();
    words.push_back(32'hDEADBEEF);
    build(1, 8'h00);
    send_all(0);
    finish_check("chk_good");
    apply_reset();
    build(1, 8'h17);
    send_all(0);
    finish_check("chk_bad");
`endif

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
